// File: rtl/rng_arbiter_pkg.sv
// Shared constants, LFSR step function and FSM encoding for the rng_arbiter slice.
package rng_arbiter_pkg;

   localparam int unsigned LFSR_W = 12;
   localparam int unsigned OUT_W  = 8;
   localparam logic [LFSR_W-1:0] SEED = 12'h815;

   // Feedback taps of the 12-bit maximal-length polynomial.
   localparam int unsigned TAP_A = 11;
   localparam int unsigned TAP_B = 5;
   localparam int unsigned TAP_C = 3;
   localparam int unsigned TAP_D = 0;

   typedef enum logic {
      ST_SERVE  = 1'b0,
      ST_WARMUP = 1'b1
   } arb_state_e;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
   endfunction

endpackage

// File: rtl/rng_lfsr_core.sv
// Shared LFSR register with load and step; a zero load value is replaced by SEED.
module rng_lfsr_core
   import rng_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              step,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_value,
   output logic [LFSR_W-1:0] state
);

   // All-zero is the lock-up state, so it can never be loaded.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SEED;
      end else if (load) begin
         state <= (load_value == '0) ? SEED : load_value;
      end else if (step) begin
         state <= lfsr_next(state);
      end
   end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin distribution of one shared LFSR stream to NREQ p-bit comparators.
// Define RNG_ARB_FREERUN_EN to let the LFSR step every SERVE cycle, granted or not.
module rng_arbiter
   import rng_arbiter_pkg::*;
#(
   parameter  int unsigned NREQ   = 4,
   parameter  int unsigned WARMUP = 16,
   localparam int unsigned ID_W   = $clog2(NREQ),
   localparam int unsigned CNT_W  = $clog2(WARMUP + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   output logic [NREQ-1:0]   gnt,
   output logic              rnd_valid,
   output logic [OUT_W-1:0]  rnd_data,
   output logic [ID_W-1:0]   rnd_id,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_value,
   output logic              seed_busy
);

`ifdef RNG_ARB_FREERUN_EN
   localparam logic FREERUN = 1'b1;
`else
   localparam logic FREERUN = 1'b0;
`endif

   arb_state_e        state;
   logic [ID_W-1:0]   last_id;
   logic [CNT_W-1:0]  warm_cnt;
   logic [LFSR_W-1:0] lfsr;

   logic              any_req_c;
   logic [ID_W-1:0]   win_id_c;
   logic [ID_W-1:0]   scan_idx_c;
   logic              step_c;
   logic              lfsr_unused_c;

   assign lfsr_unused_c = ^lfsr[LFSR_W-OUT_W-1:0];

   // Round-robin scan from last_id+1; descending loop leaves the nearest hit.
   always_comb begin
      any_req_c  = |req;
      win_id_c   = '0;
      scan_idx_c = '0;
      for (int unsigned off = NREQ; off >= 1; off--) begin
         scan_idx_c = ID_W'((32'(last_id) + off) % NREQ);
         if (req[scan_idx_c]) begin
            win_id_c = scan_idx_c;
         end
      end
   end

   assign step_c = !seed_load &&
                   ((state == ST_WARMUP) || any_req_c || FREERUN);

   rng_lfsr_core u_lfsr (
      .clk        (clk),
      .rst        (rst),
      .step       (step_c),
      .load       (seed_load),
      .load_value (seed_value),
      .state      (lfsr)
   );

   // Arbitration FSM; a reseed strobe beats any request in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_SERVE;
         last_id   <= ID_W'(NREQ - 1);
         warm_cnt  <= '0;
         gnt       <= '0;
         rnd_valid <= 1'b0;
         rnd_data  <= '0;
         rnd_id    <= '0;
         seed_busy <= 1'b0;
      end else begin
         gnt       <= '0;
         rnd_valid <= 1'b0;
         if (seed_load) begin
            state     <= ST_WARMUP;
            warm_cnt  <= CNT_W'(WARMUP);
            seed_busy <= 1'b1;
         end else begin
            case (state)
               ST_SERVE: begin
                  if (any_req_c) begin
                     gnt       <= NREQ'(1) << win_id_c;
                     rnd_valid <= 1'b1;
                     rnd_id    <= win_id_c;
                     rnd_data  <= lfsr[LFSR_W-1 -: OUT_W];
                     last_id   <= win_id_c;
                  end
               end
               ST_WARMUP: begin
                  if (warm_cnt == CNT_W'(1)) begin
                     state     <= ST_SERVE;
                     warm_cnt  <= '0;
                     seed_busy <= 1'b0;
                  end else begin
                     warm_cnt <= warm_cnt - CNT_W'(1);
                  end
               end
               default: state <= ST_SERVE;
            endcase
         end
      end
   end

endmodule
